// File: rtl/frame_writer.sv
// Ingress stage of the packet filter: writes AXI-stream beats into the frame buffer and, on
// frame end, pushes {end pointer, tdest} to the sideband buffer; discards dropped/unqueueable frames.
package frame_writer_pkg;
    localparam int AXIS_DATA_WIDTH = 16;
    localparam int AXIS_DEST_WIDTH = 4;

    typedef struct packed {
        logic [AXIS_DATA_WIDTH-1:0] tdata;
        logic [AXIS_DEST_WIDTH-1:0] tdest;
        logic                       tvalid;
        logic                       tlast;
    } axis_d_source_t;

    typedef struct packed {
        logic tready;
    } axis_d_sink_t;
endpackage

module frame_writer
    import frame_writer_pkg::*;
#(
    parameter int ADDR_WIDTH     = 11,
    parameter int HEADER_WORDS   = 7,
    parameter int DROP_CTR_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  axis_d_source_t            ingress_source,
    output axis_d_sink_t              ingress_sink,
    input  logic                      drop_frame,
    output logic                      scan_payload,
    output logic [19:0]               frame_wdata,
    output logic                      frame_wen,
    input  logic                      frame_full,
    input  logic [ADDR_WIDTH:0]       frame_wptr,
    output logic                      frame_wrst,
    output logic [ADDR_WIDTH:0]       frame_rst_wptr,
    output logic [19:0]               sideband_wdata,
    output logic                      sideband_wen,
    input  logic                      sideband_full,
    output logic [DROP_CTR_WIDTH-1:0] dropped_frames
);

    localparam int BC_W = $clog2(HEADER_WORDS + 1);
    localparam logic [BC_W-1:0] HDR_LAST = BC_W'(HEADER_WORDS);

    if (ADDR_WIDTH + 1 + AXIS_DEST_WIDTH > 20) begin : g_sideband_width_check
        $error("frame_writer: sideband entry does not fit in 20 bits");
    end
    if (HEADER_WORDS < 1) begin : g_header_words_check
        $error("frame_writer: HEADER_WORDS must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        COMMIT,
        DISCARD
    } state_t;

    state_t                      state_reg, state_next;
    logic [BC_W-1:0]             beat_ctr_reg, beat_ctr_next;
    logic                        scan_reg, scan_next;
    logic                        wrst_reg, wrst_next;
    logic [AXIS_DEST_WIDTH-1:0]  tdest_reg, tdest_next;
    logic [ADDR_WIDTH:0]         rst_wptr_reg, rst_wptr_next;
    logic [DROP_CTR_WIDTH-1:0]   drop_ctr_reg;
    logic                        drop_inc;
    logic                        tready;
    logic                        hs;
    logic [BC_W-1:0]             beat_inc;

    always_comb begin
        tready = 1'b0;
        case (state_reg)
            IDLE:            tready = ~frame_full & ~sideband_full;
            HEADER, PAYLOAD: tready = ~frame_full;
            DISCARD:         tready = 1'b1;
            default:         tready = 1'b0;
        endcase
    end

    assign hs       = ingress_source.tvalid & tready;
    assign beat_inc = beat_ctr_reg + 1'b1;

    always_comb begin
        state_next    = state_reg;
        beat_ctr_next = beat_ctr_reg;
        scan_next     = scan_reg;
        tdest_next    = tdest_reg;
        rst_wptr_next = rst_wptr_reg;
        wrst_next     = 1'b0;
        drop_inc      = 1'b0;
        frame_wen     = 1'b0;
        sideband_wen  = 1'b0;
        case (state_reg)
            IDLE: begin
                // No room for a sideband entry: swallow the whole frame.
                if (ingress_source.tvalid && sideband_full) begin
                    state_next = DISCARD;
                    drop_inc   = 1'b1;
                end else if (hs) begin
                    frame_wen     = 1'b1;
                    rst_wptr_next = frame_wptr;
                    tdest_next    = ingress_source.tdest;
                    beat_ctr_next = BC_W'(1);
                    if (ingress_source.tlast) begin
                        state_next = COMMIT;
                    end else if (HEADER_WORDS == 1) begin
                        state_next = PAYLOAD;
                        scan_next  = 1'b1;
                    end else begin
                        state_next = HEADER;
                    end
                end
            end
            HEADER: begin
                if (drop_frame) begin
                    wrst_next  = 1'b1;
                    drop_inc   = 1'b1;
                    state_next = (hs && ingress_source.tlast) ? IDLE : DISCARD;
                end else if (hs) begin
                    frame_wen     = 1'b1;
                    beat_ctr_next = beat_inc;
                    if (ingress_source.tlast) begin
                        state_next = COMMIT;
                    end else if (beat_inc == HDR_LAST) begin
                        state_next = PAYLOAD;
                        scan_next  = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (hs) begin
                    frame_wen = 1'b1;
                    if (ingress_source.tlast) begin
                        state_next = COMMIT;
                    end
                end
            end
            COMMIT: begin
                sideband_wen = 1'b1;
                scan_next    = 1'b0;
                state_next   = IDLE;
            end
            DISCARD: begin
                if (hs && ingress_source.tlast) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            beat_ctr_reg <= '0;
            scan_reg     <= 1'b0;
            wrst_reg     <= 1'b0;
            tdest_reg    <= '0;
            rst_wptr_reg <= '0;
            drop_ctr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            beat_ctr_reg <= beat_ctr_next;
            scan_reg     <= scan_next;
            wrst_reg     <= wrst_next;
            tdest_reg    <= tdest_next;
            rst_wptr_reg <= rst_wptr_next;
            if (drop_inc && (drop_ctr_reg != '1)) begin
                drop_ctr_reg <= drop_ctr_reg + 1'b1;
            end
        end
    end

    // frame_wptr already points past the last beat when COMMIT is reached.
    assign sideband_wdata      = sideband_wen ? 20'({frame_wptr, tdest_reg}) : 20'd0;
    assign frame_wdata         = {3'b000, ingress_source.tlast, ingress_source.tdata};
    assign ingress_sink.tready = tready;
    assign scan_payload        = scan_reg;
    assign frame_wrst          = wrst_reg;
    assign frame_rst_wptr      = rst_wptr_reg;
    assign dropped_frames      = drop_ctr_reg;

endmodule
